// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the four-requester shared-register arbiter.
package reg_arb_pkg;
  localparam int NREQ = 4;
  localparam int IDXW = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, modulo NREQ.
module rr_pick
  import reg_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] w_cand;

  always_comb begin
    found  = 1'b0;
    idx    = ptr;
    w_cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      // 2-bit addition wraps 3 -> 0 naturally
      w_cand = ptr + IDXW'(k);
      if (!found && req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter granting four requesters write access to one shared register.
// Optional hold-grant feature enabled by defining ARB_LOCK_EN.
module reg_share_arbiter
  import reg_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid,
  output logic [IDXW-1:0]       owner
);

  state_t          r_state;
  logic [IDXW-1:0] r_ptr;
  logic [IDXW-1:0] r_sel;
  logic [WIDTH-1:0] r_q;
  logic [NREQ-1:0] r_gnt;
  logic            r_qv;
  logic [IDXW-1:0] r_owner;

  logic            w_found;
  logic [IDXW-1:0] w_idx;

  rr_pick u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_q     <= '0;
      r_gnt   <= '0;
      r_qv    <= 1'b0;
      r_owner <= '0;
    end else begin
      // gnt and q_valid are single-cycle pulses; default them low
      r_gnt <= '0;
      r_qv  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_sel   <= w_idx;
            r_gnt   <= onehot(w_idx);
            r_state <= GRANT;
          end
        end
        GRANT: begin
          r_q     <= data[int'(r_sel)*WIDTH +: WIDTH];
          r_owner <= r_sel;
          r_ptr   <= r_sel + 2'd1;
          r_qv    <= 1'b1;
          r_state <= WRITE;
        end
        WRITE: begin
`ifdef ARB_LOCK_EN
          // Locked owner re-enters GRANT directly; ptr already equals sel+1
          if (lock[r_owner] && req[r_owner]) begin
            r_gnt   <= onehot(r_sel);
            r_state <= GRANT;
          end else begin
            r_state <= IDLE;
          end
`else
          r_state <= IDLE;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign q       = r_q;
  assign q_valid = r_qv;
  assign owner   = r_owner;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed self-checking bench for reg_share_arbiter; lock scenario runs when ARB_LOCK_EN is defined.
module tb_reg_share_arbiter;
  localparam int WIDTH = 8;

  logic              clk;
  logic              reset;
  logic [3:0]        req;
  logic [4*WIDTH-1:0] data;
`ifdef ARB_LOCK_EN
  logic [3:0]        lock;
`endif
  logic [3:0]        gnt;
  logic [WIDTH-1:0]  q;
  logic              q_valid;
  logic [1:0]        owner;

  int checks = 0;
  int errors = 0;

  reg_share_arbiter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .data    (data),
`ifdef ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .owner   (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    data[i*WIDTH +: WIDTH] = v;
  endtask

  // Advance negedges until q_valid is seen or the bound expires
  task automatic wait_valid(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n++;
      chk("gnt_qv_excl", {31'd0, (gnt != 4'd0) && q_valid}, 32'd0);
      if (q_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  int  n;
  bit  ok;

  initial begin
    reset = 1'b0;
    req   = 4'd0;
    data  = '0;
`ifdef ARB_LOCK_EN
    lock  = 4'd0;
`endif

    // Reset held, then released with no requests
    repeat (2) begin
      @(negedge clk);
      chk("rst_q", q, 0); chk("rst_gnt", gnt, 0);
      chk("rst_qv", q_valid, 0); chk("rst_owner", owner, 0);
    end
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_q", q, 0); chk("idle_gnt", gnt, 0);
      chk("idle_qv", q_valid, 0); chk("idle_owner", owner, 0);
    end

    // Single request from requester 2
    req = 4'b0100; set_data(2, 8'hA5);
    @(negedge clk);
    chk("single_gnt", gnt, 4'b0100); chk("single_qv0", q_valid, 0);
    req = 4'b0000;
    @(negedge clk);
    chk("single_q", q, 8'hA5); chk("single_owner", owner, 2);
    chk("single_qv", q_valid, 1); chk("single_gnt0", gnt, 0);
    @(negedge clk);
    chk("single_qv_end", q_valid, 0);

    // ptr must now be 3: requesters 0 and 3 pending, 3 wins
    req = 4'b1001; set_data(3, 8'h77); set_data(0, 8'h66);
    @(negedge clk);
    chk("ptr3_gnt", gnt, 4'b1000);
    req = 4'b0000;
    @(negedge clk);
    chk("ptr3_q", q, 8'h77); chk("ptr3_owner", owner, 3);
    @(negedge clk);

    // Fairness and wrap with all requesters active
    for (int i = 0; i < 4; i++) set_data(i, 8'h10 + 8'(i));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_valid(n, ok);
      chk("rr_seen", {31'd0, ok}, 1);
      chk("rr_q", q, 8'h10 + (i % 4));
      chk("rr_owner", owner, i % 4);
      chk("rr_gap", n, (i == 0) ? 2 : 3);
    end
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);

    // Requester 1 drops its request during GRANT
    req = 4'b0010; set_data(1, 8'h3C);
    @(negedge clk);
    chk("drop_gnt", gnt, 4'b0010);
    req = 4'b0000;
    @(negedge clk);
    chk("drop_q", q, 8'h3C); chk("drop_qv", q_valid, 1); chk("drop_owner", owner, 1);
    @(negedge clk);
    chk("drop_qv_end", q_valid, 0); chk("drop_gnt_end", gnt, 0);
    @(negedge clk);
    chk("drop_idle_gnt", gnt, 0);

    // Reset asserted mid-GRANT aborts the transfer (ptr was 2 before reset)
    req = 4'b0001; set_data(0, 8'hFF);
    @(negedge clk);
    chk("abort_gnt", gnt, 4'b0001);
    reset = 1'b0;
    req   = 4'b0000;
    #1;
    chk("abort_q", q, 0); chk("abort_gnt0", gnt, 0); chk("abort_owner", owner, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_qv", q_valid, 0); chk("abort_q_hold", q, 0);
    end
    req = 4'b1111;
    @(negedge clk);
    chk("abort_restart_gnt", gnt, 4'b0001);
    req = 4'b0000;
    @(negedge clk);
    chk("abort_restart_q", q, 8'hFF); chk("abort_restart_qv", q_valid, 1);
    @(negedge clk);
    @(negedge clk);

`ifdef ARB_LOCK_EN
    // Move ptr back to 0 via requester 3
    req = 4'b1000;
    @(negedge clk);
    chk("lock_pre_gnt", gnt, 4'b1000);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);

    // Locked requester 0 keeps the register for 3 back-to-back writes
    set_data(0, 8'h5A); set_data(1, 8'h5B);
    req  = 4'b0011;
    lock = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      wait_valid(n, ok);
      chk("lock_seen", {31'd0, ok}, 1);
      chk("lock_owner", owner, 0);
      chk("lock_q", q, 8'h5A);
      chk("lock_gap", n, 2);
    end
    lock = 4'b0000;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (gnt != 4'd0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("unlock_seen", {31'd0, ok}, 1);
    chk("unlock_gnt", gnt, 4'b0010);
    req = 4'b0000;
    @(negedge clk);
    chk("unlock_q", q, 8'h5B); chk("unlock_owner", owner, 1);
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
